// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants, also used by control_unit.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        STOP_LEVEL = 1'b1;

    localparam logic [31:0] UART_ADDR = 32'h0000_0204;
    localparam logic [31:0] LED_ADDR  = 32'h0000_01ec;

    // Word returned on the load_uart read path.
    typedef struct packed {
        logic [22:0] rsvd;
        logic        not_empty;
        logic [7:0]  data;
    } rx_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO: pointers plus occupancy counter, head shown combinationally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign do_pop_c  = pop & ~empty;
    assign do_push_c = push & (~full | do_pop_c);
    assign head      = empty ? '0 : mem_q[rd_ptr_q];
    assign count     = count_q;

    // Next pointer and occupancy; pointers wrap naturally at power-of-2 depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push_c && !do_pop_c)      count_d = count_q + CW'(1);
        else if (!do_push_c && do_pop_c) count_d = count_q - CW'(1);
    end

    // Pointer and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_rx_intc.sv
// 8N1 UART receiver with byte FIFO and edge-style interrupt request for control_unit.
module uart_rx_intc
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned INT_PULSE    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    input  logic                        uart_read_end,
    output logic [31:0]                 rx_data,
    output logic                        int_sig,
    output logic                        rx_overrun,
    output logic                        rx_frame_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNTW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIW  = $clog2(DATA_BITS);
    localparam int unsigned PW   = $clog2(INT_PULSE + 1);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;

    logic            rx_meta_q, rx_s_q, rx_prev_q;
    logic            fall_c;
    rx_state_e       state_q;
    logic [CNTW-1:0] cnt_q;
    logic [BIW-1:0]  bit_idx_q;
    logic [7:0]      shift_q;
    logic            stop_sample_c, push_c, ferr_c;

    logic [7:0]      head;
    logic [CW-1:0]   count;
    logic            full, empty;
    logic            pop_acc_c, ovr_set_c, event_c;

    logic            ovr_q, ferr_q;
    logic            int_q, int_d;
    logic            gap_q, gap_d;
    logic [PW-1:0]   hi_cnt_q, hi_cnt_d;
    rx_word_t        word_c;

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall_c = rx_prev_q & ~rx_s_q;

    // Frame receiver: mid-start check, then LSB-first data bits, then stop bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fall_c) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNTW'(HALF - 1)) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s_q ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNTW'(CLKS_PER_BIT - 1)) begin
                        cnt_q            <= '0;
                        shift_q[bit_idx_q] <= rx_s_q;
                        if (bit_idx_q == BIW'(DATA_BITS - 1)) state_q <= ST_STOP;
                        else bit_idx_q <= bit_idx_q + BIW'(1);
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNTW'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stop-bit sample decides between push and framing error in the same cycle.
    assign stop_sample_c = (state_q == ST_STOP) && (cnt_q == CNTW'(CLKS_PER_BIT - 1));
    assign push_c        = stop_sample_c && (rx_s_q == STOP_LEVEL);
    assign ferr_c        = stop_sample_c && (rx_s_q != STOP_LEVEL);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .wdata (shift_q),
        .pop   (uart_read_end),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Request on push into empty FIFO, or on a pop that still leaves data behind.
    assign pop_acc_c = uart_read_end & ~empty;
    assign ovr_set_c = push_c & full & ~pop_acc_c;
    assign event_c   = (push_c & empty) | (pop_acc_c & ((count > CW'(1)) | push_c));

    // Sticky error flags, cleared by the next accepted pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (ovr_set_c)      ovr_q <= 1'b1;
            else if (pop_acc_c) ovr_q <= 1'b0;
            if (ferr_c)         ferr_q <= 1'b1;
            else if (pop_acc_c) ferr_q <= 1'b0;
        end
    end

    // Interrupt pulse: a request while high inserts one low cycle so a fresh edge is seen.
    always_comb begin
        int_d    = int_q;
        gap_d    = 1'b0;
        hi_cnt_d = hi_cnt_q;
        if (event_c) begin
            if (int_q) begin
                int_d = 1'b0;
                gap_d = 1'b1;
            end else begin
                int_d    = 1'b1;
                hi_cnt_d = PW'(INT_PULSE - 1);
            end
        end else if (gap_q) begin
            int_d    = 1'b1;
            hi_cnt_d = PW'(INT_PULSE - 1);
        end else if (int_q) begin
            if (hi_cnt_q == '0) int_d = 1'b0;
            else hi_cnt_d = hi_cnt_q - PW'(1);
        end
    end

    // Interrupt pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_q    <= 1'b0;
            gap_q    <= 1'b0;
            hi_cnt_q <= '0;
        end else begin
            int_q    <= int_d;
            gap_q    <= gap_d;
            hi_cnt_q <= hi_cnt_d;
        end
    end

    // Read-path word: valid flag plus head byte.
    always_comb begin
        word_c           = '0;
        word_c.not_empty = ~empty;
        word_c.data      = head;
    end

    assign rx_data      = word_c;
    assign int_sig      = int_q;
    assign rx_overrun   = ovr_q;
    assign rx_frame_err = ferr_q;
    assign fifo_count   = count;

endmodule

// File: tb/tb_uart_rx_intc.sv
`timescale 1ns/1ps
module tb_uart_rx_intc;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PULSE = 4;
    localparam int unsigned CW    = 3;
    // Start edge -> byte visible: 9.5 bit times, 2 sync flops, 1 edge-detect flop.
    localparam int LAT = 155;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx  = 1'b1;
    logic          ure = 1'b0;
    logic [31:0]   rx_data;
    logic          int_sig, rx_overrun, rx_frame_err;
    logic [CW-1:0] fifo_count;

    uart_rx_intc #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .INT_PULSE    (PULSE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .uart_read_end (ure),
        .rx_data       (rx_data),
        .int_sig       (int_sig),
        .rx_overrun    (rx_overrun),
        .rx_frame_err  (rx_frame_err),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] data;
        bit         ok;
    } frame_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    frame_t     sched[$];
    logic [7:0] q[$];
    bit         m_ovr  = 0;
    bit         m_ferr = 0;
    bit         m_int  = 0;
    bit         ever   = 0;
    int         start_hi = 0;
    bit         done   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop1();
        ure = 1'b1;
        tick(1);
        ure = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        frame_t f;
        f.due  = cyc + LAT;
        f.data = d;
        f.ok   = stop_ok;
        sched.push_back(f);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CPB);
        end
        rx = stop_ok;
        tick(CPB);
    endtask

    // Behavioural model: byte queue, sticky flags and interrupt schedule per clock edge.
    initial begin
        bit         push, bad, pop, ev, prev;
        logic [7:0] d;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete();
                sched.delete();
                m_ovr  = 0;
                m_ferr = 0;
                m_int  = 0;
                ever   = 0;
            end else begin
                cyc++;
                push = 0;
                bad  = 0;
                d    = 8'h00;
                pop  = ure;
                if (sched.size() > 0 && sched[0].due == cyc) begin
                    push = sched[0].ok;
                    bad  = !sched[0].ok;
                    d    = sched[0].data;
                    sched.delete(0);
                end
                ev = 0;
                if (pop && q.size() > 0) begin
                    q.delete(0);
                    if (push) q.push_back(d);
                    ev     = (q.size() >= 1);
                    m_ovr  = 0;
                    m_ferr = 0;
                end else if (push) begin
                    if (q.size() == DEPTH) m_ovr = 1;
                    else begin
                        ev = (q.size() == 0);
                        q.push_back(d);
                    end
                end
                if (bad) m_ferr = 1;
                prev = m_int;
                if (ev) begin
                    start_hi = prev ? cyc + 1 : cyc;
                    ever     = 1;
                end
                m_int = ever && (cyc >= start_hi) && (cyc < start_hi + int'(PULSE));
            end
        end
    end

    // Compare every output against the model once per cycle.
    initial begin
        logic [31:0] exp_data;
        forever begin
            @(negedge clk);
            exp_data = (q.size() > 0) ? {23'b0, 1'b1, q[0]} : 32'h0;
            check("rx_data", rx_data, exp_data);
            check("fifo_count", 32'(fifo_count), 32'(q.size()));
            check("int_sig", 32'(int_sig), 32'(m_int));
            check("rx_overrun", 32'(rx_overrun), 32'(m_ovr));
            check("rx_frame_err", 32'(rx_frame_err), 32'(m_ferr));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int  hi, first, st, c0, gap;
        bit  ok;

        // Power-on reset
        tick(3);
        rst = 1'b1;
        tick(2);
        check("reset_rx_data", rx_data, 32'h0);
        check("reset_count", 32'(fifo_count), 32'd0);
        check("reset_int", 32'(int_sig), 32'd0);

        // Reset mid-traffic: buffered byte and partial frame are lost
        send_frame(8'h5A, 1);
        tick(4);
        rx = 1'b0;
        tick(40);
        rst = 1'b0;
        #1;
        check("midrst_rx_data", rx_data, 32'h0);
        check("midrst_int", 32'(int_sig), 32'd0);
        tick(3);
        rx  = 1'b1;
        rst = 1'b1;
        tick(200);
        check("postrst_count", 32'(fifo_count), 32'd0);
        check("postrst_flags", 32'({rx_overrun, rx_frame_err}), 32'd0);

        // Single byte: latency, head word, pulse width, pop to empty
        st = cyc;
        hi = 0;
        first = -1;
        fork
            send_frame(8'hA5, 1);
            begin
                repeat (165) begin
                    @(negedge clk);
                    if (int_sig) hi++;
                    if (first < 0 && fifo_count == 3'd1) first = cyc - st;
                end
            end
        join
        tick(1);
        check("a5_latency_in_window", 32'((first >= 152) && (first <= 156)), 32'd1);
        check("a5_int_width", 32'(hi), 32'd4);
        check("a5_rx_data", rx_data, 32'h0000_01A5);
        pop1();
        tick(2);
        check("a5_pop_rx_data", rx_data, 32'h0);
        check("a5_pop_int", 32'(int_sig), 32'd0);

        // Back-to-back bytes; pop re-requests with a fresh edge
        send_frame(8'h11, 1);
        send_frame(8'h22, 1);
        tick(3);
        check("b2b_head", rx_data, 32'h0000_0111);
        check("b2b_int_low_before_pop", 32'(int_sig), 32'd0);
        pop1();
        check("b2b_int_edge", 32'(int_sig), 32'd1);
        check("b2b_head_after_pop", rx_data, 32'h0000_0122);
        tick(6);
        pop1();
        tick(2);

        // Overflow: fifth byte dropped
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1);
        tick(2);
        check("ovr_count", 32'(fifo_count), 32'd4);
        check("ovr_flag", 32'(rx_overrun), 32'd1);
        check("ovr_head", rx_data, 32'h0000_0101);
        pop1();
        check("ovr_clear", 32'(rx_overrun), 32'd0);
        check("ovr_head2", rx_data, 32'h0000_0102);
        repeat (3) begin
            tick(6);
            pop1();
        end
        tick(6);

        // Start-bit glitch, then framing error with line held low
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(30);
        check("glitch_count", 32'(fifo_count), 32'd0);
        check("glitch_ferr", 32'(rx_frame_err), 32'd0);
        send_frame(8'h3C, 0);
        tick(40);
        rx = 1'b1;
        tick(5);
        check("ferr_set", 32'(rx_frame_err), 32'd1);
        check("ferr_count", 32'(fifo_count), 32'd0);
        send_frame(8'h77, 1);
        tick(2);
        pop1();
        check("ferr_clear", 32'(rx_frame_err), 32'd0);
        tick(4);

        // Push coincident with pop at count 2, then restart during active pulse
        send_frame(8'hA1, 1);
        send_frame(8'hA2, 1);
        tick(8);
        c0 = cyc;
        fork
            send_frame(8'hA3, 1);
            begin
                while (cyc < c0 + LAT - 1) tick(1);
                ure = 1'b1;
                tick(1);
                ure = 1'b0;
                check("coinc_count", 32'(fifo_count), 32'd2);
                check("coinc_head", rx_data, 32'h0000_01A2);
                check("coinc_int", 32'(int_sig), 32'd1);
                tick(1);
                ure = 1'b1;
                tick(1);
                ure = 1'b0;
                check("restart_low", 32'(int_sig), 32'd0);
                check("restart_head", rx_data, 32'h0000_01A3);
                tick(1);
                check("restart_high", 32'(int_sig), 32'd1);
            end
        join
        tick(8);
        pop1();
        tick(8);

        // Randomized frames and pops
        done = 0;
        fork
            begin
                for (int n = 0; n < 30; n++) begin
                    ok = ($urandom_range(9) != 0);
                    send_frame(8'($urandom_range(255)), ok);
                    if (!ok) begin
                        rx  = 1'b1;
                        gap = $urandom_range(20, 2);
                    end else begin
                        gap = $urandom_range(20, 0);
                    end
                    tick(gap);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    ure = ($urandom_range(5) == 0);
                    tick(1);
                end
                ure = 1'b0;
            end
        join
        repeat (8) begin
            ure = 1'b1;
            tick(1);
        end
        ure = 1'b0;
        tick(10);
        check("final_count", 32'(fifo_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
